irq_ctrl: RTL
=============

# irq_ctrl

Parametrised interrupt controller for the picoRV32 SoC. It replaces the fixed per-line `irq_5`/`irq_6`/`irq_7` wiring with `N_IRQ` generalised channels. Each channel has per-channel enable, edge/level mode, polarity and a write-1-to-clear pending bit, all accessed through registers on the CPU native memory bus. It drives the CPU `irq` vector and reports the highest-priority active channel.

## Interface
- `N_IRQ`, 8: number of interrupt channels; legal range 1..32.
- `IRQ_BASE`, 0: bit position of channel 0 within the CPU's 32-bit `irq` vector; informational only, used by the top level for wiring.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `irq_in`  in  N_IRQ  raw interrupt sources; may be asynchronous when `IRQC_SYNC_EN` is defined.
- `sel`  in  1  address-decoder select for this peripheral.
- `mem_valid`  in  1  CPU bus request.
- `mem_addr`  in  5  byte offset within the block; bits [1:0] are ignored.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write strobes; 0 means read.
- `mem_ready`  out  1  one-cycle transfer acknowledge.
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1.
- `irq_out`  out  N_IRQ  PENDING & ENABLE, to the CPU irq vector.
- `irq_any`  out  1  OR of `irq_out`.

## Operation
- Registers (offset: name, access). Bits at and above `N_IRQ` read 0 and ignore writes.
  - 0x00 PENDING: read; write-1-to-clear.
  - 0x04 ENABLE: read/write.
  - 0x08 MODE: read/write; 1 = edge, 0 = level.
  - 0x0C POLARITY: read/write; 1 = active-low / falling edge.
  - 0x10 ACTIVE: read-only; bit31 = valid, bits[4:0] = lowest-index channel with `irq_out` set, 0 when none.
  - 0x14 RAW: read-only; synchronised `irq_in` before the polarity adjustment.
  - Other offsets: reads return 0, writes are ignored, the transfer is still acknowledged.
- Per channel, the adjusted signal is `a = sync_in ^ POLARITY`.
- Edge mode: PENDING sets when `a` is 1 and `a_prev` is 0. It stays set until software clears it.
- Level mode: PENDING equals `a` every cycle; W1C writes have no effect.
- Simultaneous set and W1C on the same bit in the same cycle: the set wins and PENDING stays 1.
- Writing POLARITY may create an edge on `a` and set PENDING. Software clears PENDING after any POLARITY change.
- Masking: ENABLE gates only `irq_out`. PENDING still latches while a channel is disabled.
- Byte strobes: each set bit of `mem_wstrb` updates the corresponding byte lane only.
- Bus state machine:
  - IDLE to ACK when `mem_valid & sel & !mem_ready`.
  - ACK drives `mem_ready`=1 for exactly one cycle, then returns to IDLE.
  - Writes take effect at the clock edge that ends the ACK cycle.
  - Read data is captured at the edge entering ACK.
  - `mem_rdata` returns to 0 outside ACK.
- Back-to-back requests: one transfer completes every 2 cycles.

## Timing
- Reset values, all outputs and state 0: `mem_ready`, `mem_rdata`, `irq_out`, `irq_any`, PENDING, ENABLE, MODE, POLARITY, synchroniser stages, `a_prev`.
- Reset while in ACK: the transfer is aborted, no write is performed, and `mem_ready` is 0 on the next cycle.
- `irq_in` first sampled active at posedge k: PENDING and `irq_out` are visible after posedge k+2 with `IRQC_SYNC_EN`, and after posedge k without it.
- `irq_out` and `irq_any` are combinational from the PENDING and ENABLE flops, so there is no extra latency.
- A W1C write completing at posedge j drops `irq_out` after posedge j, unless a new edge arrives in the same cycle.
- An input held active through reset release produces one edge event in edge mode, because `a_prev` resets to 0.
- A pulse shorter than one `clk` period may be lost; the minimum active width is 1 cycle without sync and 2 cycles with sync.

## Configuration
- `IRQC_SYNC_EN` defined: a two-flop synchroniser on each `irq_in` bit; 2-cycle input latency; safe for asynchronous pins.
- `IRQC_SYNC_EN` undefined: `irq_in` feeds the edge and level logic directly; 0-cycle latency; inputs must be synchronous to `clk`.

## Test plan
- Reset with `irq_in`=0: read all six registers, all return 0; `mem_ready` pulses exactly 1 cycle per access.
- Edge mode: N_IRQ=8, MODE=0xFF, ENABLE=0x20. Pulse `irq_in[5]` high for 400 cycles. Expect PENDING=0x20, `irq_any`=1, ACTIVE=0x8000_0005. Write PENDING=0x20, then expect PENDING=0 and `irq_any`=0.
- Priority and mask: MODE=0xFF, ENABLE=0xC0. Raise `irq_in[7]`, `irq_in[6]` and `irq_in[5]` together. Expect PENDING=0xE0, `irq_out`=0xC0, ACTIVE=0x8000_0006.
- Level mode with polarity: MODE=0, POLARITY=0x01, ENABLE=0x01, `irq_in[0]`=0. Expect PENDING[0]=1. Write 1 to clear, PENDING stays 1. Drive `irq_in[0]`=1, then expect PENDING[0]=0.
- Collision: issue a W1C of bit 3 completing in the same cycle as a new rising edge on channel 3. Expect PENDING[3]=1 afterwards.
- Byte strobe: write ENABLE=0xFFFF_FFFF with `mem_wstrb`=0001 and N_IRQ=16. Expect ENABLE to read back 0x0000_00FF.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_ctrl_if : picoRV32 native memory bus slice seen by the interrupt
// controller.
//   sel        master->slave  address-decoder select for this peripheral
//   mem_valid  master->slave  bus request
//   mem_addr   master->slave  byte offset within the block ([1:0] ignored)
//   mem_wdata  master->slave  write data
//   mem_wstrb  master->slave  byte write strobes, 0 = read
//   mem_ready  slave->master  one-cycle transfer acknowledge
//   mem_rdata  slave->master  read data, valid while mem_ready = 1
// -----------------------------------------------------------------------------
interface irq_ctrl_if;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;

   logic          sel;
   logic          mem_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [SW-1:0] mem_wstrb;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;

   modport master (
      output sel, mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  sel, mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl : N_IRQ-channel interrupt controller for the picoRV32 SoC.
// Each channel has enable, edge/level mode, polarity and a W1C pending bit,
// all reachable through the CPU native memory bus.
//
// Optional feature macro: IRQC_SYNC_EN
//   defined   : two-flop synchroniser per i_irq_in bit (2-cycle latency)
//   undefined : i_irq_in feeds the edge/level logic directly
//
// Ports
//   i_clk      system clock
//   i_reset    synchronous, active-high reset
//   i_irq_in   raw interrupt sources [N_IRQ]
//   bus        irq_ctrl_if.slave register access port
//   o_irq_out  PENDING & ENABLE, to the CPU irq vector [N_IRQ]
//   o_irq_any  OR of o_irq_out
//
// Registers: 0x00 PENDING (W1C), 0x04 ENABLE, 0x08 MODE (1=edge),
//            0x0C POLARITY (1=active-low), 0x10 ACTIVE (RO), 0x14 RAW (RO)
// -----------------------------------------------------------------------------
module irq_ctrl #(
   parameter int unsigned N_IRQ    = 8,
   parameter int unsigned IRQ_BASE = 0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [N_IRQ-1:0] i_irq_in,
   irq_ctrl_if.slave        bus,
   output logic [N_IRQ-1:0] o_irq_out,
   output logic             o_irq_any
);
   localparam int unsigned NW = N_IRQ;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned RW = 3;

   localparam logic [RW-1:0] A_PENDING = 3'd0;
   localparam logic [RW-1:0] A_ENABLE  = 3'd1;
   localparam logic [RW-1:0] A_MODE    = 3'd2;
   localparam logic [RW-1:0] A_POL     = 3'd3;
   localparam logic [RW-1:0] A_ACTIVE  = 3'd4;
   localparam logic [RW-1:0] A_RAW     = 3'd5;

   typedef enum logic {ST_IDLE, ST_ACK} state_t;

   // Channel block must fit inside the CPU's 32-bit irq vector
   if (N_IRQ < 1 || N_IRQ > 32 || IRQ_BASE + N_IRQ > 32) begin : g_cfg_err
      $error("irq_ctrl: N_IRQ must be 1..32 and fit above IRQ_BASE");
   end

   state_t          r_state;
   logic            r_ready;
   logic [DW-1:0]   r_rdata;
   logic [RW-1:0]   r_addr;
   logic [DW-1:0]   r_wdata;
   logic [SW-1:0]   r_wstrb;
   logic [NW-1:0]   r_pending;
   logic [NW-1:0]   r_enable;
   logic [NW-1:0]   r_mode;
   logic [NW-1:0]   r_pol;
   logic [NW-1:0]   r_a_prev;
`ifdef IRQC_SYNC_EN
   logic [NW-1:0]   r_sync1;
   logic [NW-1:0]   r_sync2;
`endif

   logic [NW-1:0]   w_sync;
   logic [NW-1:0]   w_adj;
   logic [NW-1:0]   w_clr;
   logic [NW-1:0]   w_pend_nxt;
   logic [DW-1:0]   w_bmask;
   logic [DW-1:0]   w_wd_m;
   logic [NW-1:0]   w_enable_nxt;
   logic [NW-1:0]   w_mode_nxt;
   logic [NW-1:0]   w_pol_nxt;
   logic            w_wr;
   logic            w_req;
   logic [DW-1:0]   w_active;
   logic [DW-1:0]   w_rdata;
   logic            w_unused;

   assign w_unused = ^bus.mem_addr[1:0];

`ifdef IRQC_SYNC_EN
   assign w_sync = r_sync2;
`else
   assign w_sync = i_irq_in;
`endif

   assign o_irq_out     = r_pending & r_enable;
   assign o_irq_any     = |o_irq_out;
   assign bus.mem_ready = r_ready;
   assign bus.mem_rdata = r_rdata;

   // Write path: byte-lane merge of the data latched when the transfer began
   always_comb begin
      w_bmask      = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
      w_wd_m       = r_wdata & w_bmask;
      w_wr         = (r_state == ST_ACK) && (r_wstrb != '0);
      w_enable_nxt = NW'((DW'(r_enable) & ~w_bmask) | w_wd_m);
      w_mode_nxt   = NW'((DW'(r_mode)   & ~w_bmask) | w_wd_m);
      w_pol_nxt    = NW'((DW'(r_pol)    & ~w_bmask) | w_wd_m);
      w_clr        = (w_wr && r_addr == A_PENDING) ? NW'(w_wd_m) : '0;
      w_req        = bus.mem_valid & bus.sel & ~r_ready;
   end

   // Pending update: edge channels latch rising edges (set beats W1C),
   // level channels simply follow the adjusted input.
   always_comb begin
      w_adj      = w_sync ^ r_pol;
      w_pend_nxt = (r_mode & ((r_pending & ~w_clr) | (w_adj & ~r_a_prev)))
                 | (~r_mode & w_adj);
   end

   // Lowest-index active channel; scanning downwards lets the lowest win
   always_comb begin
      w_active = '0;
      for (int i = int'(NW) - 1; i >= 0; i--) begin
         if (o_irq_out[i]) w_active = {1'b1, 26'd0, 5'(i)};
      end
   end

   // Read mux, sampled on the edge entering ACK
   always_comb begin
      w_rdata = '0;
      case (bus.mem_addr[4:2])
         A_PENDING: w_rdata = DW'(r_pending);
         A_ENABLE:  w_rdata = DW'(r_enable);
         A_MODE:    w_rdata = DW'(r_mode);
         A_POL:     w_rdata = DW'(r_pol);
         A_ACTIVE:  w_rdata = w_active;
         A_RAW:     w_rdata = DW'(w_sync);
         default:   w_rdata = '0;
      endcase
   end

   // State, channel registers and bus handshake
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_ready   <= 1'b0;
         r_rdata   <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_pending <= '0;
         r_enable  <= '0;
         r_mode    <= '0;
         r_pol     <= '0;
         r_a_prev  <= '0;
`ifdef IRQC_SYNC_EN
         r_sync1   <= '0;
         r_sync2   <= '0;
`endif
      end else begin
`ifdef IRQC_SYNC_EN
         r_sync1   <= i_irq_in;
         r_sync2   <= r_sync1;
`endif
         r_a_prev  <= w_adj;
         r_pending <= w_pend_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_state <= ST_ACK;
                  r_ready <= 1'b1;
                  r_rdata <= w_rdata;
                  r_addr  <= bus.mem_addr[4:2];
                  r_wdata <= bus.mem_wdata;
                  r_wstrb <= bus.mem_wstrb;
               end
            end
            ST_ACK: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b0;
               r_rdata <= '0;
               if (w_wr) begin
                  case (r_addr)
                     A_ENABLE: r_enable <= w_enable_nxt;
                     A_MODE:   r_mode   <= w_mode_nxt;
                     A_POL:    r_pol    <= w_pol_nxt;
                     default:  ;
                  endcase
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b0;
               r_rdata <= '0;
            end
         endcase
      end
   end
endmodule
